i2c_target_regs: RTL and testbench

Parametrised I2C target (slave) that bridges an I2C bus to a small bank of byte-addressed configuration registers, such as PID gains, held outside this block. It supports writes and reads, including reads after a repeated START, with START/STOP detection at any point in a frame. Optional pointer auto-increment allows multi-byte bursts. It sits between the pad-level SCL/SDA signals and the register bank that feeds the controller datapath.

---
 rtl/i2c_pkg.sv | 24 ++
 rtl/i2c_line_sync.sv | 43 ++++
 rtl/i2c_target_regs.sv | 252 +++++++++++++++++++++++++
 tb/tb_i2c_target_regs.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C target register bridge.
// Optional build macro I2C_TARGET_AUTOINC_EN (see i2c_target_regs.sv).
package i2c_pkg;

    // Protocol phase of the target; exported on a debug port by the top.
    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_DEV_ADDR  = 3'd1,
        ST_ADDR_ACK  = 3'd2,
        ST_REG_ADDR  = 3'd3,
        ST_WRITE     = 3'd4,
        ST_WRITE_ACK = 3'd5,
        ST_READ      = 3'd6,
        ST_READ_ACK  = 3'd7
    } i2c_state_e;

    // Bus level of the acknowledge bit.
    localparam logic I2C_ACK  = 1'b0;
    localparam logic I2C_NACK = 1'b1;

    // Position of the R/W flag inside the device address byte (1 = read).
    localparam int RW_BIT = 0;

endpackage

// File: rtl/i2c_line_sync.sv
// Two-flop synchronizers for SCL/SDA plus edge and bus-condition detection.
// All pulses are combinational from the synchronized and one-cycle-old values,
// so an action registered on them lands 3 clk after the pad edge.
module i2c_line_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda_o,
    output logic scl_rise_o,
    output logic scl_fall_o,
    output logic start_det_o,
    output logic stop_det_o
);

    logic [1:0] scl_sync_q;
    logic [1:0] sda_sync_q;
    logic       scl_prev_q;
    logic       sda_prev_q;

    // Synchronizer chains and previous-value flops; idle bus level is high.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync_q <= 2'b11;
            sda_sync_q <= 2'b11;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[0], scl_i};
            sda_sync_q <= {sda_sync_q[0], sda_i};
            scl_prev_q <= scl_sync_q[1];
            sda_prev_q <= sda_sync_q[1];
        end
    end

    assign sda_o       = sda_sync_q[1];
    assign scl_rise_o  = scl_sync_q[1] & ~scl_prev_q;
    assign scl_fall_o  = ~scl_sync_q[1] & scl_prev_q;
    // SDA may only change with SCL high at a START (falling) or STOP (rising).
    assign start_det_o = scl_sync_q[1] & scl_prev_q & ~sda_sync_q[1] & sda_prev_q;
    assign stop_det_o  = scl_sync_q[1] & scl_prev_q & sda_sync_q[1] & ~sda_prev_q;

endmodule

// File: rtl/i2c_target_regs.sv
// I2C target bridging the bus to a small byte-addressed register bank.
// Build option: define I2C_TARGET_AUTOINC_EN to advance the register pointer
// after every written byte and every read-byte load (burst access).
// Write port contract: wr_en_o is a one-cycle strobe with no back-pressure;
// wr_idx_o/wr_data_o are valid in the same cycle and hold afterwards.
module i2c_target_regs
    import i2c_pkg::*;
#(
    parameter logic [6:0] DEV_ADDR = 7'h3F,
    parameter logic [7:0] REG_BASE = 8'h40,
    parameter int         NUM_REGS = 3,
    parameter int         DATA_W   = 6,
    localparam int        IDX_W    = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              ena_i,
    input  logic              scl_i,
    input  logic              sda_i,
    output logic              sda_oe_o,
    output logic              wr_en_o,
    output logic [IDX_W-1:0]  wr_idx_o,
    output logic [DATA_W-1:0] wr_data_o,
    output logic [IDX_W-1:0]  rd_idx_o,
    input  logic [DATA_W-1:0] rd_data_i,
    output logic              busy_o,
    output i2c_state_e        state_o
);

`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    logic sda_s, scl_rise, scl_fall, start_det, stop_det;

    i2c_line_sync u_sync (
        .clk         (clk),
        .rst_n       (rst_n),
        .scl_i       (scl_i),
        .sda_i       (sda_i),
        .sda_o       (sda_s),
        .scl_rise_o  (scl_rise),
        .scl_fall_o  (scl_fall),
        .start_det_o (start_det),
        .stop_det_o  (stop_det)
    );

    i2c_state_e        state_q, state_d;
    logic [2:0]        bit_cnt_q, bit_cnt_d;
    logic [7:0]        shift_q, shift_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic              rw_q, rw_d;
    logic              first_wr_q, first_wr_d;
    logic              sda_oe_q, sda_oe_d;
    logic              wr_en_q, wr_en_d;
    logic [IDX_W-1:0]  wr_idx_q, wr_idx_d;
    logic [DATA_W-1:0] wr_data_q, wr_data_d;
    logic              busy_q, busy_d;

    // Byte as it stands including the bit being sampled now.
    logic [7:0]       byte_in;
    logic [8:0]       reg_off;
    logic             in_range;
    logic [7:0]       rd_byte;
    logic [IDX_W-1:0] ptr_inc;
    logic             wr_ok;

    assign byte_in  = {shift_q[6:0], sda_s};
    assign reg_off  = {1'b0, byte_in} - {1'b0, REG_BASE};
    assign in_range = ~reg_off[8] && (reg_off < 9'(NUM_REGS));
    assign rd_byte  = 8'(rd_data_i);
    assign ptr_inc  = (ptr_q == IDX_W'(NUM_REGS - 1)) ? '0 : ptr_q + IDX_W'(1);
    // Without auto-increment only the first data byte after REG_ADDR is taken.
    assign wr_ok    = AUTOINC || first_wr_q;

    // State and datapath registers; ena low aborts exactly like reset.
    always_ff @(posedge clk) begin
        if (!rst_n || !ena_i) begin
            state_q    <= ST_IDLE;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            ptr_q      <= '0;
            rw_q       <= 1'b0;
            first_wr_q <= 1'b0;
            sda_oe_q   <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_idx_q   <= '0;
            wr_data_q  <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
            ptr_q      <= ptr_d;
            rw_q       <= rw_d;
            first_wr_q <= first_wr_d;
            sda_oe_q   <= sda_oe_d;
            wr_en_q    <= wr_en_d;
            wr_idx_q   <= wr_idx_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
        end
    end

    // Next-state logic: bus conditions first, then per-state SCL edge handling.
    // ACK phases use sda_oe_q as the sub-phase: first SCL fall drives, second ends.
    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        ptr_d      = ptr_q;
        rw_d       = rw_q;
        first_wr_d = first_wr_q;
        sda_oe_d   = sda_oe_q;
        wr_en_d    = 1'b0;
        wr_idx_d   = wr_idx_q;
        wr_data_d  = wr_data_q;
        busy_d     = busy_q;

        if (start_det) begin
            state_d   = ST_DEV_ADDR;
            bit_cnt_d = '0;
            sda_oe_d  = 1'b0;
            busy_d    = 1'b1;
        end else if (stop_det) begin
            state_d  = ST_IDLE;
            sda_oe_d = 1'b0;
            busy_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    sda_oe_d = 1'b0;
                end
                ST_DEV_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (byte_in[7:1] == DEV_ADDR) begin
                                state_d = ST_ADDR_ACK;
                                rw_d    = byte_in[RW_BIT];
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_ADDR_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else if (rw_q) begin
                            shift_d   = rd_byte;
                            sda_oe_d  = ~rd_byte[7];
                            bit_cnt_d = '0;
                            ptr_d     = AUTOINC ? ptr_inc : ptr_q;
                            state_d   = ST_READ;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_REG_ADDR;
                        end
                    end
                end
                ST_REG_ADDR: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (in_range) begin
                                ptr_d      = reg_off[IDX_W-1:0];
                                first_wr_d = 1'b1;
                                state_d    = ST_WRITE_ACK;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_WRITE: begin
                    if (scl_rise) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            if (wr_ok) begin
                                wr_en_d    = 1'b1;
                                wr_idx_d   = ptr_q;
                                wr_data_d  = byte_in[DATA_W-1:0];
                                ptr_d      = AUTOINC ? ptr_inc : ptr_q;
                                first_wr_d = 1'b0;
                                state_d    = ST_WRITE_ACK;
                            end else begin
                                state_d = ST_IDLE;
                            end
                        end
                    end
                end
                ST_WRITE_ACK: begin
                    if (scl_fall) begin
                        if (!sda_oe_q) begin
                            sda_oe_d = ~I2C_ACK;
                        end else begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_WRITE;
                        end
                    end
                end
                ST_READ: begin
                    // Each SCL fall presents the next bit; the 8th fall releases SDA.
                    if (scl_fall) begin
                        if (bit_cnt_q == 3'd7) begin
                            sda_oe_d  = 1'b0;
                            bit_cnt_d = '0;
                            state_d   = ST_READ_ACK;
                        end else begin
                            shift_d   = shift_q << 1;
                            sda_oe_d  = ~shift_q[6];
                            bit_cnt_d = bit_cnt_q + 3'd1;
                        end
                    end
                end
                ST_READ_ACK: begin
                    if (scl_rise && (sda_s == I2C_NACK)) begin
                        state_d = ST_IDLE;
                    end else if (scl_fall) begin
                        shift_d   = rd_byte;
                        sda_oe_d  = ~rd_byte[7];
                        bit_cnt_d = '0;
                        ptr_d     = AUTOINC ? ptr_inc : ptr_q;
                        state_d   = ST_READ;
                    end
                end
                default: begin
                    state_d  = ST_IDLE;
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    assign sda_oe_o  = sda_oe_q;
    assign wr_en_o   = wr_en_q;
    assign wr_idx_o  = wr_idx_q;
    assign wr_data_o = wr_data_q;
    assign rd_idx_o  = ptr_q;
    assign busy_o    = busy_q;
    assign state_o   = state_q;

endmodule

// File: tb/tb_i2c_target_regs.sv
// Directed bench for i2c_target_regs: bit-banged I2C master, external
// register bank model for reads, and a write scoreboard.
module tb_i2c_target_regs;
    import i2c_pkg::*;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ena = 1'b1;
    int   cyc = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- bus and DUT ----------------
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_line;
    logic       sda_oe;
    logic       wr_en;
    logic [1:0] wr_idx;
    logic [5:0] wr_data;
    logic [1:0] rd_idx;
    logic [5:0] rd_data;
    logic       busy;
    i2c_state_e dut_state;
    logic [5:0] bank [4];

    assign sda_line = sda_m & ~sda_oe;
    assign rd_data  = bank[rd_idx];

    i2c_target_regs dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ena_i     (ena),
        .scl_i     (scl_m),
        .sda_i     (sda_line),
        .sda_oe_o  (sda_oe),
        .wr_en_o   (wr_en),
        .wr_idx_o  (wr_idx),
        .wr_data_o (wr_data),
        .rd_idx_o  (rd_idx),
        .rd_data_i (rd_data),
        .busy_o    (busy),
        .state_o   (dut_state)
    );

`ifdef I2C_TARGET_AUTOINC_EN
    localparam bit AUTOINC = 1'b1;
`else
    localparam bit AUTOINC = 1'b0;
`endif

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_pass   = 0;
    int bit0_cyc = 0;
    logic prev_wr = 1'b0;
    logic [7:0] exp_q[$];   // expected writes as {idx[1:0], data[5:0]}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Scoreboard: every write strobe must match the oldest expected write.
    always @(negedge clk) begin
        if (wr_en) begin
            check("wr_en_width", 32'(prev_wr), 32'd0);
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL wr_unexpected: got idx %0d data %0h expected no write", wr_idx, wr_data);
            end else begin
                logic [7:0] e;
                e = exp_q.pop_front();
                check("wr_idx", 32'(wr_idx), 32'(e[7:6]));
                check("wr_data", 32'(wr_data), 32'(e[5:0]));
                check("wr_latency", 32'(cyc - bit0_cyc), 32'd3);
            end
        end
        prev_wr <= wr_en;
    end

    // ---------------- I2C master driver tasks ----------------
    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic i2c_start();
        sda_m = 1'b1; wait_clk(4);
        scl_m = 1'b1; wait_clk(8);
        sda_m = 1'b0; wait_clk(8);
        scl_m = 1'b0; wait_clk(4);
    endtask

    task automatic i2c_stop();
        sda_m = 1'b0; wait_clk(4);
        scl_m = 1'b1; wait_clk(8);
        sda_m = 1'b1; wait_clk(8);
    endtask

    task automatic send_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_m = b[i]; wait_clk(4);
            scl_m = 1'b1;
            if (i == 0) bit0_cyc = cyc;
            wait_clk(8);
            scl_m = 1'b0; wait_clk(4);
        end
    endtask

    // ack = 1 when the target pulled SDA low in the 9th clock.
    task automatic write_byte(input logic [7:0] b, output logic ack);
        send_bits(b, 8);
        sda_m = 1'b1; wait_clk(4);
        scl_m = 1'b1; wait_clk(4);
        ack = ~sda_line; wait_clk(4);
        scl_m = 1'b0; wait_clk(4);
    endtask

    task automatic read_byte(input logic mack, output logic [7:0] b);
        for (int i = 7; i >= 0; i--) begin
            sda_m = 1'b1; wait_clk(4);
            scl_m = 1'b1; wait_clk(4);
            b[i] = sda_line; wait_clk(4);
            scl_m = 1'b0; wait_clk(4);
        end
        sda_m = ~mack; wait_clk(4);
        scl_m = 1'b1; wait_clk(8);
        scl_m = 1'b0; wait_clk(4);
    endtask

    // ---------------- write vector table ----------------
    typedef struct {
        logic [7:0] dev;
        logic [7:0] rega;
        int         nd;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [3:0] exp_ack;   // bit0 dev, bit1 reg, bit2 d0, bit3 d1
        int         nw;
        logic [7:0] w0;
        logic [7:0] w1;
    } wvec_t;

    localparam int NV = 6;
    wvec_t vecs [NV];

    task automatic run_read_wrap_tests();
        logic a;
        logic [7:0] rb;
        // Read from 0x40 via repeated START, three bytes.
        i2c_start();
        write_byte(8'h7E, a); check("rd1_dev_ack", 32'(a), 32'd1);
        write_byte(8'h40, a); check("rd1_reg_ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'h7F, a); check("rd1_rdev_ack", 32'(a), 32'd1);
        read_byte(1'b1, rb); check("rd1_byte0", 32'(rb), 32'h2A);
        read_byte(1'b1, rb); check("rd1_byte1", 32'(rb), AUTOINC ? 32'h15 : 32'h2A);
        read_byte(1'b0, rb); check("rd1_byte2", 32'(rb), AUTOINC ? 32'h33 : 32'h2A);
        check("rd1_nack_state", 32'(dut_state), 32'(ST_IDLE));
        check("rd1_nack_sda", 32'(sda_oe), 32'd0);
        check("rd1_busy_before_stop", 32'(busy), 32'd1);
        i2c_stop();
        check("rd1_busy_after_stop", 32'(busy), 32'd0);
        // Read from the last register; with auto-increment it wraps to 0.
        i2c_start();
        write_byte(8'h7E, a);
        write_byte(8'h42, a); check("rd2_reg_ack", 32'(a), 32'd1);
        i2c_start();
        write_byte(8'h7F, a);
        read_byte(1'b1, rb); check("rd2_byte0", 32'(rb), 32'h33);
        read_byte(1'b0, rb); check("rd2_byte1", 32'(rb), AUTOINC ? 32'h2A : 32'h33);
        i2c_stop();
    endtask

    // Start a read at register 1 and stop after the first bit is being driven.
    task automatic open_read_frame();
        logic a;
        i2c_start();
        write_byte(8'h7E, a);
        write_byte(8'h41, a);
        i2c_start();
        write_byte(8'h7F, a);
        check("abort_read_driving", 32'(sda_oe), 32'd1);
        check("abort_read_state", 32'(dut_state), 32'(ST_READ));
    endtask

    initial begin
        logic a;
        logic [3:0] got;

        bank[0] = 6'h2A; bank[1] = 6'h15; bank[2] = 6'h33; bank[3] = 6'h00;

        vecs[0] = '{8'h7C, 8'h00, 0, 8'h00, 8'h00, 4'b0000, 0, 8'h00, 8'h00};
        vecs[1] = '{8'h7E, 8'h43, 1, 8'h11, 8'h00, 4'b0001, 0, 8'h00, 8'h00};
        vecs[2] = '{8'h7E, 8'h3F, 1, 8'h11, 8'h00, 4'b0001, 0, 8'h00, 8'h00};
        vecs[3] = '{8'h7E, 8'h40, 1, 8'hFF, 8'h00, 4'b0111, 1, 8'h3F, 8'h00};
        if (AUTOINC)
            vecs[4] = '{8'h7E, 8'h42, 2, 8'h01, 8'h02, 4'b1111, 2, 8'h81, 8'h02};
        else
            vecs[4] = '{8'h7E, 8'h42, 2, 8'h01, 8'h02, 4'b0111, 1, 8'h81, 8'h00};
        vecs[5] = '{8'h7E, 8'h41, 1, 8'h25, 8'h00, 4'b0111, 1, 8'h65, 8'h00};

        // Reset values.
        wait_clk(5);
        rst_n = 1'b1;
        wait_clk(2);
        check("rst_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_wr_en", 32'(wr_en), 32'd0);
        check("rst_wr_idx", 32'(wr_idx), 32'd0);
        check("rst_wr_data", 32'(wr_data), 32'd0);
        check("rst_rd_idx", 32'(rd_idx), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_state", 32'(dut_state), 32'(ST_IDLE));

        run_read_wrap_tests();

        // Table-driven write frames.
        for (int v = 0; v < NV; v++) begin
            if (vecs[v].nw > 0) exp_q.push_back(vecs[v].w0);
            if (vecs[v].nw > 1) exp_q.push_back(vecs[v].w1);
            got = 4'b0000;
            i2c_start();
            write_byte(vecs[v].dev, a); got[0] = a;
            if (got[0]) begin
                write_byte(vecs[v].rega, a); got[1] = a;
            end
            if (got[1]) begin
                for (int k = 0; k < vecs[v].nd; k++) begin
                    write_byte((k == 0) ? vecs[v].d0 : vecs[v].d1, a);
                    got[2 + k] = a;
                    if (!a) break;
                end
            end
            check($sformatf("v%0d_acks", v), 32'(got), 32'(vecs[v].exp_ack));
            check($sformatf("v%0d_busy_in_frame", v), 32'(busy), 32'd1);
            i2c_stop();
            check($sformatf("v%0d_busy_after_stop", v), 32'(busy), 32'd0);
            check($sformatf("v%0d_wr_missing", v), 32'(exp_q.size()), 32'd0);
        end

        // STOP after 4 bits of a data byte: no strobe, back to idle.
        i2c_start();
        write_byte(8'h7E, a);
        write_byte(8'h41, a);
        send_bits(8'h55, 4);
        i2c_stop();
        check("stop_mid_state", 32'(dut_state), 32'(ST_IDLE));
        check("stop_mid_busy", 32'(busy), 32'd0);
        check("stop_mid_wr_idx_held", 32'(wr_idx), 32'd1);

        // rst_n low mid-READ.
        open_read_frame();
        rst_n = 1'b0;
        wait_clk(1);
        check("rst_mid_sda_oe", 32'(sda_oe), 32'd0);
        check("rst_mid_wr_en", 32'(wr_en), 32'd0);
        check("rst_mid_wr_idx", 32'(wr_idx), 32'd0);
        check("rst_mid_wr_data", 32'(wr_data), 32'd0);
        check("rst_mid_rd_idx", 32'(rd_idx), 32'd0);
        check("rst_mid_busy", 32'(busy), 32'd0);
        check("rst_mid_state", 32'(dut_state), 32'(ST_IDLE));
        rst_n = 1'b1;
        i2c_stop();

        // ena low mid-READ.
        open_read_frame();
        check("ena_pre_rd_idx", 32'(rd_idx), AUTOINC ? 32'd2 : 32'd1);
        ena = 1'b0;
        wait_clk(1);
        check("ena_mid_sda_oe", 32'(sda_oe), 32'd0);
        check("ena_mid_rd_idx", 32'(rd_idx), 32'd0);
        check("ena_mid_busy", 32'(busy), 32'd0);
        check("ena_mid_state", 32'(dut_state), 32'(ST_IDLE));
        ena = 1'b1;
        i2c_stop();
        wait_clk(10);
        check("final_wr_queue_empty", 32'(exp_q.size()), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    // Guard against a hung run.
    initial begin
        #900000;
        $display("FAIL timeout: simulation did not finish, got %0d checks expected completion", n_checks);
        $fatal(1, "timeout");
    end

endmodule
